// File: rtl/sba_resp_pkg.sv
// Shared types and constants for the SBA bus responder.
package sba_resp_pkg;

  localparam int SBA_MAX_DW = 64;  // widest DATA_WIDTH the response struct can carry
  localparam int LAT_CNT_W  = 4;   // holds LATENCY-1 for LATENCY up to 15

  typedef enum logic [1:0] {IDLE, STALL, RESP} resp_state_e;

  typedef struct packed {
    logic [SBA_MAX_DW-1:0] rdata;
    logic                  rerr;
    logic                  rother_err;
  } resp_t;

  function automatic int num_lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/sba_resp_mem.sv
// Single-port word RAM with per-byte write enables; combinational read.
module sba_resp_mem
  import sba_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 256,
  parameter int IDX_W      = 8
) (
  input  logic                            clk_i,
  input  logic                            we_i,
  input  logic [IDX_W-1:0]                idx_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  input  logic [num_lanes(DATA_WIDTH)-1:0] be_i,
  output logic [DATA_WIDTH-1:0]           rdata_o
);

  localparam int NUM_LANES = num_lanes(DATA_WIDTH);

  logic [NUM_LANES-1:0][7:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (be_i[l]) mem_q[idx_i][l] <= wdata_i[l*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/sba_bus_responder.sv
// SBA bus target: grants one transaction at a time, serves it from a local
// byte-enabled RAM and returns a single-cycle response LATENCY cycles later.
module sba_bus_responder
  import sba_resp_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    GNT_STALL  = 0,
  parameter int                    LATENCY    = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             slave_req_i,
  input  logic [ADDR_WIDTH-1:0]            slave_addr_i,
  input  logic                             slave_we_i,
  input  logic [DATA_WIDTH-1:0]            slave_wdata_i,
  input  logic [num_lanes(DATA_WIDTH)-1:0] slave_be_i,
  output logic                             slave_gnt_o,
  output logic                             slave_rvalid_o,
  output logic                             slave_rerr_o,
  output logic                             slave_rother_err_o,
  output logic [DATA_WIDTH-1:0]            slave_rdata_o
);

  localparam int IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int STALL_W = (GNT_STALL > 1) ? $clog2(GNT_STALL) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_WORDS_A = ADDR_WIDTH'(MEM_WORDS);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("sba_bus_responder: LATENCY must be in 1..15");
  end
  if (DATA_WIDTH > SBA_MAX_DW || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("sba_bus_responder: DATA_WIDTH must be a multiple of 8 and <= SBA_MAX_DW");
  end

  resp_state_e           state_q, state_d;
  logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  resp_t                 resp_q, resp_d;
  logic                  gnt, rvalid;

  // Address decode; addresses below BASE_ADDR must not wrap into range.
  logic [ADDR_WIDTH-1:0] addr_off, word_off;
  logic                  in_range, misaligned, access_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign addr_off   = slave_addr_i - BASE_ADDR;
  assign word_off   = addr_off >> 2;
  assign in_range   = (slave_addr_i >= BASE_ADDR) && (word_off < MEM_WORDS_A);
  assign misaligned = |slave_addr_i[1:0];
  assign access_ok  = in_range && !misaligned;

  sba_resp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (gnt && slave_we_i && access_ok),
    .idx_i   (word_off[IDX_W-1:0]),
    .wdata_i (slave_wdata_i),
    .be_i    (slave_be_i),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    resp_d            = '0;
    resp_d.rerr       = !in_range;
    resp_d.rother_err = in_range && misaligned;
    if (!slave_we_i && access_ok) resp_d.rdata = SBA_MAX_DW'(mem_rdata);
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    gnt         = 1'b0;
    rvalid      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (slave_req_i) begin
          if (GNT_STALL == 0) begin
            gnt       = 1'b1;
            state_d   = RESP;
            lat_cnt_d = LAT_CNT_W'(LATENCY - 1);
          end else begin
            state_d     = STALL;
            stall_cnt_d = STALL_W'(GNT_STALL - 1);
          end
        end
      end
      STALL: begin
        if (!slave_req_i) begin
          state_d = IDLE;
        end else if (stall_cnt_q == '0) begin
          gnt       = 1'b1;
          state_d   = RESP;
          lat_cnt_d = LAT_CNT_W'(LATENCY - 1);
        end else begin
          stall_cnt_d = stall_cnt_q - STALL_W'(1);
        end
      end
      RESP: begin
        if (lat_cnt_q == '0) begin
          rvalid  = 1'b1;
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset kills any grant (and its memory write) or response this cycle.
    if (rst_i) begin
      gnt    = 1'b0;
      rvalid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      lat_cnt_q   <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      if (gnt) resp_q <= resp_d;
    end
  end

  assign slave_gnt_o        = gnt;
  assign slave_rvalid_o     = rvalid;
  assign slave_rdata_o      = rvalid ? DATA_WIDTH'(resp_q.rdata) : '0;
  assign slave_rerr_o       = rvalid && resp_q.rerr;
  assign slave_rother_err_o = rvalid && resp_q.rother_err;

endmodule

// File: tb/tb_sba_bus_responder.sv
// Scoreboard bench: three responders (LAT1/STALL0, LAT3/STALL2, LAT4/STALL0).
module tb_sba_bus_responder;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic        req    [3];
  logic        we_s   [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [3:0]  be     [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic        rerr   [3];
  logic        roth   [3];
  logic [31:0] rdata  [3];

  typedef struct {
    logic [31:0] rdata;
    logic        rerr;
    logic        roth;
  } exp_t;

  exp_t sb_q [3][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   gnt_cyc [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sba_bus_responder #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_WORDS  (256),
      .BASE_ADDR  (32'h0),
      .GNT_STALL  ((g == 1) ? 2 : 0),
      .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk_i              (clk),
      .rst_i              (rst[g]),
      .slave_req_i        (req[g]),
      .slave_addr_i       (addr[g]),
      .slave_we_i         (we_s[g]),
      .slave_wdata_i      (wdata[g]),
      .slave_be_i         (be[g]),
      .slave_gnt_o        (gnt[g]),
      .slave_rvalid_o     (rvalid[g]),
      .slave_rerr_o       (rerr[g]),
      .slave_rother_err_o (roth[g]),
      .slave_rdata_o      (rdata[g])
    );
  end

  // Monitor: pops an expected response for every rvalid and checks latency.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    for (int i = 0; i < 3; i++) begin
      if (gnt[i]) begin
        checks++;
        if (rvalid[i]) begin
          errors++;
          $display("FAIL gnt_with_rvalid[%0d] gnt=%0b rvalid=%0b, required rvalid=0", i, gnt[i], rvalid[i]);
        end
        gnt_cyc[i] = cyc;
      end
      if (rvalid[i]) begin
        checks++;
        lat = cyc - gnt_cyc[i];
        if (sb_q[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid[%0d] rdata=%h rerr=%0b roth=%0b, required no rvalid", i, rdata[i], rerr[i], roth[i]);
        end else begin
          e = sb_q[i].pop_front();
          if (rdata[i] !== e.rdata || rerr[i] !== e.rerr || roth[i] !== e.roth || lat != lat_of(i)) begin
            errors++;
            $display("FAIL rsp[%0d] rdata=%h rerr=%0b roth=%0b lat=%0d, required rdata=%h rerr=%0b roth=%0b lat=%0d",
                     i, rdata[i], rerr[i], roth[i], lat, e.rdata, e.rerr, e.roth, lat_of(i));
          end
        end
      end else if (rdata[i] !== 32'h0 || rerr[i] !== 1'b0 || roth[i] !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL idle_out[%0d] rdata=%h rerr=%0b roth=%0b, required all 0", i, rdata[i], rerr[i], roth[i]);
      end
    end
  end

  // Issue one transaction, check the grant wait, and queue the expected response.
  task automatic xact(input int i, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] er, input logic ee, input logic eo,
                      input int ew, input bit hold, output int gc);
    int   n;
    bit   got;
    exp_t e;
    req[i] = 1'b1; we_s[i] = we; addr[i] = a; wdata[i] = d; be[i] = b;
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      if (gnt[i]) got = 1'b1;
      else n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL gnt_timeout[%0d] addr=%h waited=%0d, required gnt after %0d", i, a, n, ew);
    end else begin
      if (n != ew) begin
        errors++;
        $display("FAIL gnt_wait[%0d] addr=%h waited=%0d, required %0d", i, a, n, ew);
      end
      e.rdata = er; e.rerr = ee; e.roth = eo;
      sb_q[i].push_back(e);
    end
    gc = cyc;
    @(posedge clk); #1;
    if (!hold) begin
      req[i] = 1'b0;
      repeat (lat_of(i) + 1) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g1, g2, n;
    bit got;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we_s[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; be[i] = '0;
      gnt_cyc[i] = 0;
    end
    // Request held during reset must not be granted.
    req[0] = 1'b1; addr[0] = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gnt[i] || rvalid[i] || rdata[i] != 0 || rerr[i] || roth[i]) begin
        errors++;
        $display("FAIL reset_out[%0d] gnt=%0b rvalid=%0b rdata=%h rerr=%0b roth=%0b, required all 0",
                 i, gnt[i], rvalid[i], rdata[i], rerr[i], roth[i]);
      end
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(posedge clk); #1;

    // Instance 0: LATENCY=1, GNT_STALL=0
    xact(0, 1'b1, 32'h10,  32'hABCDABCD, 4'hF, 32'h0,        1'b0, 1'b0, 0, 0, g1);
    xact(0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hABCDABCD, 1'b0, 1'b0, 0, 0, g1);
    xact(0, 1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0, 1'b0, 0, 0, g1);
    xact(0, 1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 1'b0, 0, 0, g1);
    xact(0, 1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0, 1'b0, 0, 0, g1);
    xact(0, 1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 0, 0, g1);
    xact(0, 1'b1, 32'h12,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b0, 1'b1, 0, 0, g1);
    xact(0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hABCDABCD, 1'b0, 1'b0, 0, 0, g1);
    xact(0, 1'b0, 32'h402, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 0, 0, g1);
    xact(0, 1'b1, 32'h10,  32'h00000000, 4'h0, 32'h0,        1'b0, 1'b0, 0, 0, g1);
    xact(0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hABCDABCD, 1'b0, 1'b0, 0, 0, g1);
    xact(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 1'b0, 0, 0, g1);
    xact(0, 1'b0, 32'h3FC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 1'b0, 0, 0, g1);
    xact(0, 1'b0, 32'hFFFFFFFC, 32'h0,   4'h0, 32'h0,        1'b1, 1'b0, 0, 0, g1);
    xact(0, 1'b1, 32'h14,  32'h14141414, 4'hF, 32'h0,        1'b0, 1'b0, 0, 0, g1);
    // Back-to-back reads with req held high.
    xact(0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hABCDABCD, 1'b0, 1'b0, 0, 1, g1);
    xact(0, 1'b0, 32'h14,  32'h0,        4'h0, 32'h14141414, 1'b0, 1'b0, 1, 0, g2);
    checks++;
    if (g2 - g1 != 2) begin
      errors++;
      $display("FAIL b2b_spacing gap=%0d, required 2", g2 - g1);
    end

    // Instance 1: GNT_STALL=2, LATENCY=3
    xact(1, 1'b1, 32'h10, 32'h5EED0001, 4'hF, 32'h0,        1'b0, 1'b0, 2, 0, g1);
    req[1] = 1'b1; we_s[1] = 1'b0; addr[1] = 32'h10;
    @(posedge clk); #1;
    req[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    xact(1, 1'b0, 32'h10, 32'h0,        4'h0, 32'h5EED0001, 1'b0, 1'b0, 2, 0, g1);

    // Instance 2: LATENCY=4, reset while a response is pending
    xact(2, 1'b1, 32'h10, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b0, 1'b0, 0, 0, g1);
    xact(2, 1'b0, 32'h10, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0, 1'b0, 0, 0, g1);
    req[2] = 1'b1; we_s[2] = 1'b0; addr[2] = 32'h10;
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      if (gnt[2]) got = 1'b1;
      else n++;
    end
    checks++;
    if (!got || n != 0) begin
      errors++;
      $display("FAIL abort_gnt got=%0b waited=%0d, required gnt after 0", got, n);
    end
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    xact(2, 1'b0, 32'h10, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0, 1'b0, 0, 0, g1);

    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sb_q[i].size() != 0) begin
        errors++;
        $display("FAIL missing_rsp[%0d] pending=%0d, required 0", i, sb_q[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
